hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 13 +
 rtl/hazard_cmp.sv | 22 ++
 rtl/sat_counter.sv | 30 +++
 rtl/hazard_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM state encoding and
// the hard-wired zero register index.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one pipeline destination against both ID source registers;
// register zero and non-writing stages never match.
module hazard_cmp
  import hazard_unit_pkg::*;
(
  input  logic [4:0] dest,
  input  logic       wb,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       use1,
  input  logic       use2,
  output logic       match1,
  output logic       match2
);

  logic dest_live_s;

  assign dest_live_s = wb && (dest != REG_ZERO);
  assign match1      = dest_live_s && use1 && (dest == src1);
  assign match2      = dest_live_s && use2 && (dest == src2);

endmodule

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous reset and a synchronous clear
// that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear first, then increment until all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: detects data hazards against EXE/MEM, sequences
// load-use stalls and branch flushes, and counts stall/flush cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             two_src,
  input  logic             is_st_br,
  input  logic             id_valid,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb,
  input  logic             br_taken,
  input  logic             forward_en,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_r;
  hz_state_t next_s;

  logic use1_s;
  logic use2_s;
  logic exe_m1_s;
  logic exe_m2_s;
  logic mem_m1_s;
  logic mem_m2_s;
  logic exe_hit_s;
  logic mem_hit_s;
  logic hazard_s;

  assign use1_s = id_valid;
  assign use2_s = id_valid && (two_src || is_st_br);

  hazard_cmp u_cmp_exe (
    .dest   (exe_dest),
    .wb     (exe_wb),
    .src1   (src1),
    .src2   (src2),
    .use1   (use1_s),
    .use2   (use2_s),
    .match1 (exe_m1_s),
    .match2 (exe_m2_s)
  );

  hazard_cmp u_cmp_mem (
    .dest   (mem_dest),
    .wb     (mem_wb),
    .src1   (src1),
    .src2   (src2),
    .use1   (use1_s),
    .use2   (use2_s),
    .match1 (mem_m1_s),
    .match2 (mem_m2_s)
  );

  assign exe_hit_s = exe_m1_s || exe_m2_s;
  assign mem_hit_s = mem_m1_s || mem_m2_s;
  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard_s  = forward_en ? (exe_hit_s && exe_mem_read)
                                : (exe_hit_s || mem_hit_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and stall/bubble/flush decode; branch beats hazard.
  always_comb begin
    next_s = state_r;
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (rst) begin
      next_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (br_taken) begin
            flush  = 1'b1;
            next_s = FLUSH;
          end else if (hazard_s) begin
            stall  = 1'b1;
            bubble = 1'b1;
            next_s = forward_en ? LDSTALL : RUN;
          end else begin
            next_s = RUN;
          end
        end
        LDSTALL: begin
          if (br_taken) begin
            flush  = 1'b1;
            next_s = FLUSH;
          end else begin
            next_s = RUN;
          end
        end
        FLUSH: begin
          flush  = 1'b1;
          next_s = br_taken ? FLUSH : RUN;
        end
        default: begin
          next_s = RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (4-bit counters so saturation is reachable).
module tb_hazard_unit;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [4:0]    src1;
  logic [4:0]    src2;
  logic          two_src;
  logic          is_st_br;
  logic          id_valid;
  logic [4:0]    exe_dest;
  logic          exe_wb;
  logic          exe_mem_read;
  logic [4:0]    mem_dest;
  logic          mem_wb;
  logic          br_taken;
  logic          forward_en;
  logic          cnt_clr;
  logic          stall;
  logic          bubble;
  logic          flush;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks;
  int errors;

  hazard_unit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .is_st_br     (is_st_br),
    .id_valid     (id_valid),
    .exe_dest     (exe_dest),
    .exe_wb       (exe_wb),
    .exe_mem_read (exe_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb       (mem_wb),
    .br_taken     (br_taken),
    .forward_en   (forward_en),
    .cnt_clr      (cnt_clr),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src1 = 5'd0; src2 = 5'd0; two_src = 1'b0; is_st_br = 1'b0; id_valid = 1'b0;
    exe_dest = 5'd0; exe_wb = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 5'd0; mem_wb = 1'b0; br_taken = 1'b0; forward_en = 1'b1;
    cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic load_use();
    id_valid = 1'b1; forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb = 1'b1;
    exe_dest = 5'd5; src1 = 5'd5;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    chk("rst_fcnt", 32'(flush_cnt), 32'd0);
    // Hazard present during reset must not leak out.
    load_use();
    br_taken = 1'b1;
    #1;
    chk("rst_gate_stall", 32'(stall), 32'd0);
    chk("rst_gate_flush", 32'(flush), 32'd0);
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Load-use: one stall cycle, forward_en change in LDSTALL is ignored.
    load_use();
    #1;
    chk("lu_stall1", 32'(stall), 32'd1);
    chk("lu_bubble1", 32'(bubble), 32'd1);
    tick();
    forward_en = 1'b0;
    #1;
    chk("lu_stall2", 32'(stall), 32'd0);
    chk("lu_bubble2", 32'(bubble), 32'd0);
    tick();
    chk("lu_back_run", 32'(stall), 32'd1);
    idle();
    #1;
    chk("lu_scnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("lu_scnt_hold", 32'(stall_cnt), 32'd1);

    // No forwarding: MEM hit on src2 stalls every cycle it persists.
    clear_counters();
    forward_en = 1'b0; id_valid = 1'b1; mem_wb = 1'b1; mem_dest = 5'd7;
    src2 = 5'd7; two_src = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nf_stall", 32'(stall), 32'd1);
      tick();
    end
    idle();
    #1;
    chk("nf_stall_off", 32'(stall), 32'd0);
    chk("nf_scnt", 32'(stall_cnt), 32'd3);

    // Branch beats simultaneous load-use; flush spans two cycles.
    clear_counters();
    load_use();
    br_taken = 1'b1;
    #1;
    chk("br_flush1", 32'(flush), 32'd1);
    chk("br_stall1", 32'(stall), 32'd0);
    chk("br_bubble1", 32'(bubble), 32'd0);
    tick();
    br_taken = 1'b0;
    #1;
    chk("br_flush2", 32'(flush), 32'd1);
    chk("br_stall2", 32'(stall), 32'd0);
    tick();
    idle();
    #1;
    chk("br_flush3", 32'(flush), 32'd0);
    chk("br_fcnt", 32'(flush_cnt), 32'd2);
    chk("br_scnt", 32'(stall_cnt), 32'd0);

    // Register zero and unused src2 never hazard; same src2 used does.
    idle();
    id_valid = 1'b1; exe_wb = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd0; src1 = 5'd0;
    #1;
    chk("r0_fwd", 32'(stall), 32'd0);
    forward_en = 1'b0;
    #1;
    chk("r0_nofwd", 32'(stall), 32'd0);
    forward_en = 1'b1; exe_dest = 5'd9; src1 = 5'd3; src2 = 5'd9;
    #1;
    chk("src2_unused", 32'(stall), 32'd0);
    is_st_br = 1'b1;
    #1;
    chk("src2_st_br", 32'(stall), 32'd1);
    is_st_br = 1'b0; id_valid = 1'b0; two_src = 1'b1;
    #1;
    chk("id_invalid", 32'(stall), 32'd0);
    idle();
    tick();

    // Asynchronous reset in the middle of LDSTALL.
    clear_counters();
    load_use();
    tick();
    br_taken = 1'b1;
    #1;
    chk("ld_br_flush", 32'(flush), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_flush", 32'(flush), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_scnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("ar_restall", 32'(stall), 32'd1);
    tick();
    idle();
    tick();

    // Saturation at all-ones, then clear wins over a live stall.
    clear_counters();
    forward_en = 1'b0; id_valid = 1'b1; mem_wb = 1'b1; mem_dest = 5'd12; src1 = 5'd12;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) chk("sat_10", 32'(stall_cnt), 32'd10);
    end
    chk("sat_20", 32'(stall_cnt), 32'd15);
    chk("sat_still_stall", 32'(stall), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_prio", 32'(stall_cnt), 32'd0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
